// File: rtl/merge_stream_unit.sv
// Two-run stream merger: compares the head words of two sorted input FIFOs and
// emits the merged sequence through a one-word output register (dout/ovld).
// Optional input-order checker is built when MERGE_ORDER_CHECK_EN is defined.
module merge_stream_unit #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int DESCEND = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  run_len,
  input  logic [DATA_W-1:0] din_1,
  input  logic [DATA_W-1:0] din_2,
  input  logic              valid_1,
  input  logic              valid_2,
  output logic              deq_1,
  output logic              deq_2,
  input  logic              full,
  output logic [DATA_W-1:0] dout,
  output logic              enq,
  output logic              busy,
  output logic              done,
  output logic              order_err,
  output logic [2:0]        dbg_state
);

  // Handshake: an input word transfers in any cycle where deq_x is high (deq_x
  // only rises with valid_x); an output word transfers when enq = ovld & !full.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MERGE  = 3'd1,
    S_DRAIN1 = 3'd2,
    S_DRAIN2 = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt1, cnt2;
  logic             ovld;
  logic             accept;
  logic             take_1;
  logic             load;
  logic             done_nxt;

  assign accept    = !ovld || !full;
  assign enq       = ovld && !full;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Ties always go to input 1 so equal keys keep their run order.
  always_comb begin
    if (DESCEND != 0) take_1 = (din_1 >= din_2);
    else              take_1 = (din_1 <= din_2);
  end

  always_comb begin
    state_nxt = state;
    deq_1     = 1'b0;
    deq_2     = 1'b0;
    done_nxt  = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (run_len == '0) ? S_FLUSH : S_MERGE;
        end
      end
      S_MERGE: begin
        if (valid_1 && valid_2 && accept && cnt1 != '0 && cnt2 != '0) begin
          if (take_1) begin
            deq_1 = 1'b1;
            if (cnt1 == LEN_ONE) state_nxt = S_DRAIN2;
          end else begin
            deq_2 = 1'b1;
            if (cnt2 == LEN_ONE) state_nxt = S_DRAIN1;
          end
        end
      end
      S_DRAIN1: begin
        if (valid_1 && accept && cnt1 != '0) begin
          deq_1 = 1'b1;
          if (cnt1 == LEN_ONE) state_nxt = S_FLUSH;
        end
      end
      S_DRAIN2: begin
        if (valid_2 && accept && cnt2 != '0) begin
          deq_2 = 1'b1;
          if (cnt2 == LEN_ONE) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!ovld || enq) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt1  <= '0;
      cnt2  <= '0;
      ovld  <= 1'b0;
      dout  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (load) begin
        cnt1 <= run_len;
        cnt2 <= run_len;
      end else begin
        if (deq_1) cnt1 <= cnt1 - LEN_ONE;
        if (deq_2) cnt2 <= cnt2 - LEN_ONE;
      end
      // A new word may replace the one leaving on this edge; ovld stays high.
      if (deq_1) begin
        ovld <= 1'b1;
        dout <= din_1;
      end else if (deq_2) begin
        ovld <= 1'b1;
        dout <= din_2;
      end else if (enq) begin
        ovld <= 1'b0;
      end
    end
  end

`ifdef MERGE_ORDER_CHECK_EN
  logic [DATA_W-1:0] prev_1, prev_2;
  logic              seen_1, seen_2;

  function automatic logic out_of_order(input logic [DATA_W-1:0] prev,
                                        input logic [DATA_W-1:0] cur);
    return (DESCEND != 0) ? (cur > prev) : (cur < prev);
  endfunction

  // Predecessor tracking restarts with each run so runs are checked independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_1    <= '0;
      prev_2    <= '0;
      seen_1    <= 1'b0;
      seen_2    <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (load) begin
        seen_1 <= 1'b0;
        seen_2 <= 1'b0;
      end
      if (deq_1) begin
        prev_1 <= din_1;
        seen_1 <= 1'b1;
        if (seen_1 && out_of_order(prev_1, din_1)) order_err <= 1'b1;
      end
      if (deq_2) begin
        prev_2 <= din_2;
        seen_2 <= 1'b1;
        if (seen_2 && out_of_order(prev_2, din_2)) order_err <= 1'b1;
      end
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_stream_unit.sv
// Bench for merge_stream_unit: an ascending and a descending instance, input
// FIFOs modelled as queues, expected output built by a queue-level merge model.
module tb_merge_stream_unit;
  localparam int DW = 32;
  localparam int LW = 16;
`ifdef MERGE_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  logic          clk, rst_n, start_a, start_d, valid_1, valid_2, full;
  logic [LW-1:0] run_len;
  logic [DW-1:0] din_1, din_2;
  logic          a_deq_1, a_deq_2, a_enq, a_busy, a_done, a_err;
  logic          d_deq_1, d_deq_2, d_enq, d_busy, d_done, d_err;
  logic [DW-1:0] a_dout, d_dout;
  logic [2:0]    a_dbg, d_dbg;

  logic [DW-1:0] in1_q[$], in2_q[$], exp_q[$];
  int            src_q[$];
  int            total = 0;
  int            bad = 0;

  merge_stream_unit #(.DATA_W(DW), .LEN_W(LW), .DESCEND(0)) u_asc (
    .clk(clk), .rst_n(rst_n), .start(start_a), .run_len(run_len),
    .din_1(din_1), .din_2(din_2), .valid_1(valid_1), .valid_2(valid_2),
    .deq_1(a_deq_1), .deq_2(a_deq_2), .full(full), .dout(a_dout), .enq(a_enq),
    .busy(a_busy), .done(a_done), .order_err(a_err), .dbg_state(a_dbg)
  );

  merge_stream_unit #(.DATA_W(DW), .LEN_W(LW), .DESCEND(1)) u_desc (
    .clk(clk), .rst_n(rst_n), .start(start_d), .run_len(run_len),
    .din_1(din_1), .din_2(din_2), .valid_1(valid_1), .valid_2(valid_2),
    .deq_1(d_deq_1), .deq_2(d_deq_2), .full(full), .dout(d_dout), .enq(d_enq),
    .busy(d_busy), .done(d_done), .order_err(d_err), .dbg_state(d_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference merge: repeatedly take the preferred head (ties -> run 1), then the leftovers.
  task automatic build_model(input bit desc);
    logic [DW-1:0] a[$], b[$];
    bit t1;
    a = in1_q;
    b = in2_q;
    exp_q.delete();
    src_q.delete();
    while (a.size() > 0 && b.size() > 0) begin
      t1 = desc ? (a[0] >= b[0]) : (a[0] <= b[0]);
      if (t1) begin exp_q.push_back(a.pop_front()); src_q.push_back(1); end
      else    begin exp_q.push_back(b.pop_front()); src_q.push_back(2); end
    end
    while (a.size() > 0) begin exp_q.push_back(a.pop_front()); src_q.push_back(1); end
    while (b.size() > 0) begin exp_q.push_back(b.pop_front()); src_q.push_back(2); end
  endtask

  task automatic gen_runs(input bit desc, input int len);
    logic [DW-1:0] v;
    in1_q.delete();
    in2_q.delete();
    for (int i = 0; i < len; i++) begin
      v = $urandom_range(0, 15); in1_q.push_back(v);
      v = $urandom_range(0, 15); in2_q.push_back(v);
    end
    if (desc) begin in1_q.rsort(); in2_q.rsort(); end
    else      begin in1_q.sort();  in2_q.sort();  end
  endtask

  // driver + scoreboard for one clock cycle
  task automatic step(input bit desc, input bit vrand, input bit full_v, input bit st,
                      output bit o_d1, output bit o_d2, output bit o_enq, output bit o_done,
                      output bit o_busy, output bit o_err, output logic [DW-1:0] o_dout);
    logic [DW-1:0] exp_v, junk;
    int exp_s, got_s;
    @(negedge clk);
    start_a = st && !desc;
    start_d = st && desc;
    if (st) run_len = 16'd7;
    valid_1 = (in1_q.size() > 0) && (!vrand || $urandom_range(0, 3) != 0);
    valid_2 = (in2_q.size() > 0) && (!vrand || $urandom_range(0, 3) != 0);
    din_1 = '0;
    din_2 = '0;
    if (in1_q.size() > 0) din_1 = in1_q[0];
    if (in2_q.size() > 0) din_2 = in2_q[0];
    full = full_v;
    #1;
    o_d1   = desc ? d_deq_1 : a_deq_1;
    o_d2   = desc ? d_deq_2 : a_deq_2;
    o_enq  = desc ? d_enq   : a_enq;
    o_done = desc ? d_done  : a_done;
    o_busy = desc ? d_busy  : a_busy;
    o_err  = desc ? d_err   : a_err;
    o_dout = desc ? d_dout  : a_dout;
    total++;
    if (o_d1 && o_d2) begin
      bad++; $display("FAIL both_deq: got deq_1=1 deq_2=1 want at most one");
    end
    total++;
    if ((o_d1 && !valid_1) || (o_d2 && !valid_2)) begin
      bad++; $display("FAIL deq_no_valid: got deq=%b%b valid=%b%b", o_d1, o_d2, valid_1, valid_2);
    end
    if (o_d1 || o_d2) begin
      total++;
      got_s = o_d1 ? 1 : 2;
      if (src_q.size() == 0) begin
        bad++; $display("FAIL deq_extra: got deq from input %0d want none", got_s);
      end else begin
        exp_s = src_q.pop_front();
        if (got_s != exp_s) begin
          bad++; $display("FAIL deq_src: got input %0d want input %0d", got_s, exp_s);
        end
      end
      if (o_d1 && in1_q.size() > 0) junk = in1_q.pop_front();
      else if (o_d2 && in2_q.size() > 0) junk = in2_q.pop_front();
    end
    if (o_enq) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL enq_extra: got dout=%0d want no enq", o_dout);
      end else begin
        exp_v = exp_q.pop_front();
        if (o_dout !== exp_v) begin
          bad++; $display("FAIL dout: got %0d want %0d", o_dout, exp_v);
        end
      end
    end
  endtask

  // full_mode: 0 = never full, 1 = full for cycles 3..6, 2 = random full
  task automatic run_merge(input string name, input bit desc, input int len, input int full_mode,
                           input bit vrand, input bit mid_start);
    bit d1, d2, e, dn, b, er, fv;
    logic [DW-1:0] od, held;
    int enq_cnt, first_enq, last_enq, done_cyc, done_cnt;
    build_model(desc);
    @(negedge clk);
    start_a = !desc; start_d = desc; run_len = LW'(len);
    valid_1 = 1'b0; valid_2 = 1'b0; full = 1'b0;
    enq_cnt = 0; first_enq = -1; last_enq = -1; done_cyc = -1; done_cnt = 0;
    held = '0; er = 1'b0; b = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      fv = (full_mode == 1) ? (cyc >= 3 && cyc <= 6) :
           (full_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      step(desc, vrand, fv, mid_start && cyc == 2, d1, d2, e, dn, b, er, od);
      if (cyc == 0) begin
        total++;
        if (b !== 1'b1) begin bad++; $display("FAIL %s busy: got %b want 1", name, b); end
      end
      if (full_mode == 1 && fv) begin
        total++;
        if (d1 || d2 || e) begin
          bad++; $display("FAIL %s backpressure: got deq=%b%b enq=%b want 000", name, d1, d2, e);
        end
        if (cyc == 3) held = od;
        else begin
          total++;
          if (od !== held) begin bad++; $display("FAIL %s dout_hold: got %0d want %0d", name, od, held); end
        end
      end
      if (e) begin
        enq_cnt++;
        if (first_enq < 0) first_enq = cyc;
        last_enq = cyc;
      end
      if (dn) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt); end
    total++;
    if (enq_cnt != 2 * len) begin bad++; $display("FAIL %s enq_count: got %0d want %0d", name, enq_cnt, 2 * len); end
    total++;
    if (len > 0) begin
      if (done_cyc != last_enq + 1) begin
        bad++; $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, last_enq + 1);
      end
    end else if (done_cyc != 1) begin
      bad++; $display("FAIL %s done_timing: got cycle %0d want 1", name, done_cyc);
    end
    if (full_mode == 0 && !vrand && len > 0) begin
      total++;
      if (first_enq != 1 || last_enq - first_enq != 2 * len - 1) begin
        bad++; $display("FAIL %s throughput: got enq cycles %0d..%0d want 1..%0d", name, first_enq, last_enq, 2 * len);
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL %s missing_words: got %0d left want 0", name, exp_q.size()); end
    total++;
    if (b !== 1'b0 || er !== 1'b0) begin
      bad++; $display("FAIL %s end_state: got busy=%b order_err=%b want 0 0", name, b, er);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_a = 1'b0; start_d = 1'b0; run_len = '0;
    din_1 = '0; din_2 = '0; valid_1 = 1'b0; valid_2 = 1'b0; full = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({a_deq_1, a_deq_2, a_enq, a_busy, a_done, a_err} !== 6'b0 || a_dout !== '0) begin
      bad++; $display("FAIL reset_asc: got flags=%b dout=%0d want 0", {a_deq_1, a_deq_2, a_enq, a_busy, a_done, a_err}, a_dout);
    end
    total++;
    if ({d_deq_1, d_deq_2, d_enq, d_busy, d_done, d_err} !== 6'b0 || d_dout !== '0) begin
      bad++; $display("FAIL reset_desc: got flags=%b dout=%0d want 0", {d_deq_1, d_deq_2, d_enq, d_busy, d_done, d_err}, d_dout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({a_busy, a_done, d_busy, d_done} !== 4'b0) begin
      bad++; $display("FAIL reset_release: got busy/done=%b want 0000", {a_busy, a_done, d_busy, d_done});
    end
  endtask

  task automatic test_ascending;
    in1_q = '{32'd1, 32'd4, 32'd9};
    in2_q = '{32'd2, 32'd3, 32'd10};
    run_merge("ascending", 1'b0, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ties_drain;
    in1_q = '{32'd5, 32'd5};
    in2_q = '{32'd5, 32'd7};
    run_merge("ties_drain", 1'b0, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    gen_runs(1'b0, 4);
    run_merge("backpressure", 1'b0, 4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_descend;
    in1_q = '{32'd9, 32'd3};
    in2_q = '{32'd8, 32'd8};
    run_merge("descend", 1'b1, 2, 0, 1'b0, 1'b0);
    in1_q.delete(); in2_q.delete();
    run_merge("desc_len0", 1'b1, 0, 0, 1'b0, 1'b0);
    run_merge("asc_len0", 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    bit desc, vr, ms;
    int len, fm;
    for (int it = 0; it < 24; it++) begin
      desc = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 6);
      fm   = ($urandom_range(0, 1) == 1) ? 2 : 0;
      vr   = 1'($urandom_range(0, 1));
      ms   = 1'($urandom_range(0, 1));
      gen_runs(desc, len);
      run_merge("random", desc, len, fm, vr, ms);
    end
  endtask

  task automatic test_reset_mid_merge;
    bit d1, d2, e, dn, b, er;
    logic [DW-1:0] od;
    int enq_seen;
    in1_q = '{32'd1, 32'd4, 32'd9};
    in2_q = '{32'd2, 32'd3, 32'd10};
    build_model(1'b0);
    @(negedge clk);
    start_a = 1'b1; run_len = 16'd3;
    enq_seen = 0;
    for (int cyc = 0; cyc < 20 && enq_seen < 3; cyc++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, d1, d2, e, dn, b, er, od);
      if (e) enq_seen++;
    end
    total++;
    if (enq_seen != 3) begin bad++; $display("FAIL midreset_reach: got %0d enq want 3", enq_seen); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_deq_1, a_deq_2, a_enq, a_busy, a_done, a_err} !== 6'b0 || a_dout !== '0) begin
      bad++; $display("FAIL midreset_outputs: got flags=%b dout=%0d want 0", {a_deq_1, a_deq_2, a_enq, a_busy, a_done, a_err}, a_dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in1_q.delete(); in2_q.delete(); exp_q.delete(); src_q.delete();
    for (int cyc = 0; cyc < 3; cyc++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, d1, d2, e, dn, b, er, od);
      total++;
      if (dn || e || b) begin bad++; $display("FAIL midreset_quiet: got done=%b enq=%b busy=%b want 000", dn, e, b); end
    end
    in1_q = '{32'd1, 32'd4, 32'd9};
    in2_q = '{32'd2, 32'd3, 32'd10};
    run_merge("after_reset", 1'b0, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_order_check;
    bit d1, d2, e, dn, b, er, exp_err;
    logic [DW-1:0] od;
    int deq1_cnt, done_seen;
    in1_q = '{32'd4, 32'd2};
    in2_q = '{32'd9, 32'd9};
    build_model(1'b0);
    @(negedge clk);
    start_a = 1'b1; run_len = 16'd2;
    deq1_cnt = 0; done_seen = 0;
    for (int cyc = 0; cyc < 40 && done_seen == 0; cyc++) begin
      exp_err = ORDER_EN && (deq1_cnt >= 2);
      step(1'b0, 1'b0, 1'b0, 1'b0, d1, d2, e, dn, b, er, od);
      total++;
      if (er !== exp_err) begin bad++; $display("FAIL order_err: got %b want %b at cycle %0d", er, exp_err, cyc); end
      if (d1) deq1_cnt++;
      if (dn) done_seen = 1;
    end
    total++;
    if (done_seen == 0 || exp_q.size() != 0) begin
      bad++; $display("FAIL order_run: got done=%0d left=%0d want 1 0", done_seen, exp_q.size());
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, d1, d2, e, dn, b, er, od);
    total++;
    if (er !== ORDER_EN) begin bad++; $display("FAIL order_sticky: got %b want %b", er, ORDER_EN); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (a_err !== 1'b0) begin bad++; $display("FAIL order_reset: got %b want 0", a_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_ties_drain();
    test_backpressure();
    test_descend();
    test_random();
    test_reset_mid_merge();
    test_order_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
